// File: rtl/cvmcu_dbg_pkg.sv
// Shared types and parameter defaults for the debug halt controller.
// Pure declarations: no latency, no flow control.
package cvmcu_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_HALTED  = 2'd2,
      ST_RELEASE = 2'd3
   } dbg_state_e;

   localparam int unsigned SYNC_STAGES_DEF    = 2;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
   localparam int unsigned RELEASE_CYCLES_DEF = 4;

endpackage

// File: rtl/cvmcu_dbg_sync.sv
// Multi-flop synchronizer for one asynchronous level; latency DEPTH clk edges.
// No flow control: the input level is simply resampled every cycle.
module cvmcu_dbg_sync
   import cvmcu_dbg_pkg::*;
#(
   parameter int unsigned DEPTH = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] sync_q;
   logic [DEPTH-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[DEPTH-2:0], d_i};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/cvmcu_dbg_halt_ctrl.sv
// Debug halt handshake between external debugger and core, with timer freeze and timeout.
// Request reaches the core SYNC_STAGES+1 edges after debug_req_i rises; no backpressure.
module cvmcu_dbg_halt_ctrl
   import cvmcu_dbg_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       debug_req_i,
   input  logic       core_halted_i,
   output logic       core_debug_req_o,
   output logic       stoptimer_o,
   output logic       timeout_o,
   output logic [7:0] halt_cnt_o
);

   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  REL_LAST = (RELEASE_CYCLES == 0) ? 8'd0 : 8'(RELEASE_CYCLES - 1);

   dbg_state_e  state_q, state_d;
   logic [15:0] to_cnt_q, to_cnt_d;
   logic [7:0]  rel_cnt_q, rel_cnt_d;
   logic [7:0]  halt_cnt_q, halt_cnt_d;
   logic        blocked_q, blocked_d;
   logic        req_q, req_d;
   logic        stop_q, stop_d;
   logic        to_q, to_d;
   logic        sync_req;

   cvmcu_dbg_sync #(
      .DEPTH (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (debug_req_i),
      .q_o     (sync_req)
   );

   always_comb begin
      state_d   = state_q;
      to_d      = 1'b0;
      rel_cnt_d = rel_cnt_q;
      // After a timeout the request must be seen low once before it can re-arm.
      blocked_d = blocked_q && sync_req;

      case (state_q)
         ST_IDLE: begin
            if (core_halted_i) begin
               state_d = ST_HALTED;
            end else if (sync_req && !blocked_q) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (core_halted_i) begin
               state_d = ST_HALTED;
            end else if (!sync_req) begin
               state_d = ST_IDLE;
            end else if (to_cnt_q == TO_LAST) begin
               state_d   = ST_IDLE;
               to_d      = 1'b1;
               blocked_d = 1'b1;
            end
         end
         ST_HALTED: begin
            if (!core_halted_i) begin
               if (RELEASE_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_RELEASE;
                  rel_cnt_d = '0;
               end
            end
         end
         ST_RELEASE: begin
            if (core_halted_i) begin
               state_d = ST_HALTED;
            end else if (rel_cnt_q == REL_LAST) begin
               state_d = ST_IDLE;
            end else begin
               rel_cnt_d = rel_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      to_cnt_d = (state_q == ST_REQ && state_d == ST_REQ) ? to_cnt_q + 16'd1 : '0;

      // Re-entry from RELEASE is the same halt, so only IDLE/REQ entries count.
      halt_cnt_d = halt_cnt_q;
      if (state_d == ST_HALTED && (state_q == ST_IDLE || state_q == ST_REQ)
          && halt_cnt_q != 8'hFF) begin
         halt_cnt_d = halt_cnt_q + 8'd1;
      end

      req_d  = (state_d == ST_REQ);
      stop_d = (state_d == ST_HALTED) || (state_d == ST_RELEASE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         to_cnt_q   <= '0;
         rel_cnt_q  <= '0;
         halt_cnt_q <= '0;
         blocked_q  <= 1'b0;
         req_q      <= 1'b0;
         stop_q     <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         to_cnt_q   <= to_cnt_d;
         rel_cnt_q  <= rel_cnt_d;
         halt_cnt_q <= halt_cnt_d;
         blocked_q  <= blocked_d;
         req_q      <= req_d;
         stop_q     <= stop_d;
         to_q       <= to_d;
      end
   end

   assign core_debug_req_o = req_q;
   assign stoptimer_o      = stop_q;
   assign timeout_o        = to_q;
   assign halt_cnt_o       = halt_cnt_q;

endmodule

// File: tb/tb_cvmcu_dbg_halt_ctrl.sv
// Bench for cvmcu_dbg_halt_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model (request delay line, countdown release, age-based timeout).
module tb_cvmcu_dbg_halt_ctrl;

   localparam int T_CYC = 8;
   localparam int R_CYC = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       debug_req_i = 1'b0;
   logic       core_halted_i = 1'b0;
   logic       core_debug_req_o;
   logic       stoptimer_o;
   logic       timeout_o;
   logic [7:0] halt_cnt_o;
   logic [10:0] obs;

   int vectors = 0;
   int miscompares = 0;

   // Model state: request delay line, phase flags, countdowns.
   bit m_s1, m_s2, m_req, m_stop, m_to, m_blocked;
   int m_rel_left, m_age, m_cnt;

   always #5 clk = ~clk;

   cvmcu_dbg_halt_ctrl #(
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (T_CYC),
      .RELEASE_CYCLES (R_CYC)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .debug_req_i      (debug_req_i),
      .core_halted_i    (core_halted_i),
      .core_debug_req_o (core_debug_req_o),
      .stoptimer_o      (stoptimer_o),
      .timeout_o        (timeout_o),
      .halt_cnt_o       (halt_cnt_o)
   );

   assign obs = {core_debug_req_o, stoptimer_o, timeout_o, halt_cnt_o};

   function automatic logic [10:0] exp_vec();
      return {m_req, m_stop, m_to, 8'(m_cnt)};
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_req = 0; m_stop = 0; m_to = 0; m_blocked = 0;
      m_rel_left = 0; m_age = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input bit din, input bit ch);
      bit sreq;
      sreq = m_s2;
      m_to = 0;
      if (m_stop) begin
         if (m_rel_left == 0) begin
            if (!ch) begin
               if (R_CYC == 0) m_stop = 0;
               else m_rel_left = R_CYC;
            end
         end else if (ch) begin
            m_rel_left = 0;
         end else begin
            m_rel_left--;
            if (m_rel_left == 0) m_stop = 0;
         end
      end else if (m_req) begin
         if (ch) begin
            m_req = 0; m_stop = 1; m_rel_left = 0;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         end else if (!sreq) begin
            m_req = 0;
         end else if (m_age == T_CYC) begin
            m_req = 0; m_to = 1; m_blocked = 1;
         end else begin
            m_age++;
         end
      end else begin
         if (ch) begin
            m_stop = 1; m_rel_left = 0;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         end else if (sreq && !m_blocked) begin
            m_req = 1; m_age = 1;
         end
      end
      if (!sreq) m_blocked = 0;
      m_s2 = m_s1;
      m_s1 = din;
   endtask

   task automatic step(input bit din, input bit ch);
      @(negedge clk);
      debug_req_i = din;
      core_halted_i = ch;
      @(posedge clk);
      model_edge(din, ch);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      debug_req_i = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      vectors++;
      if (obs !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_async: got %h want 000", obs);
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (obs !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_held: got %h want 000", obs);
      end
      @(negedge clk);
      reset_n = 1'b1;
      debug_req_i = 1'b0;
      @(posedge clk);
      model_edge(0, 0);
      #1;
      for (int i = 0; i < 3; i++) begin
         step(0, 0);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_idle[%0d]: got %h want %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_normal_halt();
      int cnt0;
      cnt0 = m_cnt;
      for (int i = 1; i <= 3; i++) begin
         step(1, 0);
         vectors++;
         if (core_debug_req_o !== (i == 3)) begin
            miscompares++;
            $display("FAIL req_latency edge %0d: got %b want %b", i, core_debug_req_o, (i == 3));
         end
      end
      step(1, 1);
      vectors++;
      if (stoptimer_o !== 1'b1 || core_debug_req_o !== 1'b0 || halt_cnt_o !== 8'(cnt0 + 1)) begin
         miscompares++;
         $display("FAIL halt_entry: got stop=%b req=%b cnt=%0d want stop=1 req=0 cnt=%0d",
                  stoptimer_o, core_debug_req_o, halt_cnt_o, cnt0 + 1);
      end
      vectors++;
      if (obs !== exp_vec()) begin
         miscompares++;
         $display("FAIL halt_entry_model: got %h want %h", obs, exp_vec());
      end
   endtask

   task automatic test_resume();
      step(0, 1);
      step(0, 1);
      for (int i = 1; i <= 6; i++) begin
         step(0, 0);
         vectors++;
         if (stoptimer_o !== (i <= 4) || core_debug_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_hold cycle %0d: got stop=%b req=%b want stop=%b req=0",
                     i, stoptimer_o, core_debug_req_o, (i <= 4));
         end
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL resume_model cycle %0d: got %h want %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_timeout();
      int pulses, reqcyc;
      pulses = 0;
      reqcyc = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 0);
         pulses += int'(timeout_o);
         reqcyc += int'(core_debug_req_o);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL timeout_model[%0d]: got %h want %h", i, obs, exp_vec());
         end
      end
      vectors++;
      if (pulses !== 1) begin
         miscompares++;
         $display("FAIL timeout_pulses: got %0d want 1", pulses);
      end
      vectors++;
      if (reqcyc !== T_CYC) begin
         miscompares++;
         $display("FAIL timeout_req_cycles: got %0d want %0d", reqcyc, T_CYC);
      end
      step(0, 0);
      for (int i = 1; i <= 3; i++) begin
         step(1, 0);
         vectors++;
         if (core_debug_req_o !== (i == 3)) begin
            miscompares++;
            $display("FAIL rearm edge %0d: got %b want %b", i, core_debug_req_o, (i == 3));
         end
      end
   endtask

   task automatic test_abort();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0);
         pulses += int'(timeout_o);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL abort_model[%0d]: got %h want %h", i, obs, exp_vec());
         end
      end
      vectors++;
      if (pulses !== 0 || core_debug_req_o !== 1'b0) begin
         miscompares++;
         $display("FAIL abort: got pulses=%0d req=%b want pulses=0 req=0", pulses, core_debug_req_o);
      end
   endtask

   task automatic test_core_entry();
      int cnt0;
      cnt0 = m_cnt;
      step(0, 1);
      vectors++;
      if (stoptimer_o !== 1'b1 || halt_cnt_o !== 8'(cnt0 + 1)) begin
         miscompares++;
         $display("FAIL core_entry: got stop=%b cnt=%0d want stop=1 cnt=%0d",
                  stoptimer_o, halt_cnt_o, cnt0 + 1);
      end
      step(0, 1);
      vectors++;
      if (halt_cnt_o !== 8'(cnt0 + 1)) begin
         miscompares++;
         $display("FAIL core_entry_hold: got cnt=%0d want %0d", halt_cnt_o, cnt0 + 1);
      end
   endtask

   task automatic test_rehalt();
      int cnt0;
      cnt0 = m_cnt;
      step(0, 0);
      step(0, 0);
      step(0, 1);
      vectors++;
      if (stoptimer_o !== 1'b1 || halt_cnt_o !== 8'(cnt0)) begin
         miscompares++;
         $display("FAIL rehalt: got stop=%b cnt=%0d want stop=1 cnt=%0d", stoptimer_o, halt_cnt_o, cnt0);
      end
      for (int i = 0; i < 6; i++) step(0, 0);
      vectors++;
      if (obs !== exp_vec() || stoptimer_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rehalt_exit: got %h want %h", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      bit din, ch;
      din = 0;
      ch = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) din = ~din;
         if ($urandom_range(0, 9) == 0) ch = ~ch;
         step(din, ch);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
         end
      end
      for (int i = 0; i < 8; i++) step(0, 0);
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 260; k++) begin
         step(0, 1);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL sat_entry[%0d]: got %h want %h", k, obs, exp_vec());
         end
         for (int i = 0; i < 5; i++) step(0, 0);
      end
      vectors++;
      if (halt_cnt_o !== 8'd255) begin
         miscompares++;
         $display("FAIL saturation: got %0d want 255", halt_cnt_o);
      end
   endtask

   task automatic test_reset_mid_halt();
      step(0, 1);
      vectors++;
      if (stoptimer_o !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_halt: got stop=%b want 1", stoptimer_o);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (obs !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_mid_halt: got %h want 000", obs);
      end
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      model_edge(0, 1);
      #1;
      vectors++;
      if (stoptimer_o !== 1'b1 || halt_cnt_o !== 8'd1) begin
         miscompares++;
         $display("FAIL resume_after_reset: got stop=%b cnt=%0d want stop=1 cnt=1",
                  stoptimer_o, halt_cnt_o);
      end
      for (int i = 0; i < 6; i++) begin
         step(0, 0);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL post_reset[%0d]: got %h want %h", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal_halt();
      test_resume();
      test_timeout();
      test_abort();
      test_core_entry();
      test_rehalt();
      test_random();
      test_saturation();
      test_reset_mid_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cvmcu_dbg_halt_ctrl.md
CVMCU_DBG_HALT_CTRL -- requirements
Module: cvmcu_dbg_halt_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth for debug_req_i (legal range 2..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the core-halt acknowledge timeout in clk cycles (legal range 1..65535).
REQ-003 Parameter RELEASE_CYCLES, default 4, SHALL set the stoptimer_o hold time after the core exits debug (legal range 0..255).
REQ-004 clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n, input, 1: SHALL be the asynchronous, active-low reset.
REQ-006 debug_req_i, input, 1: SHALL be the asynchronous level debug request from the external debugger.
REQ-007 core_halted_i, input, 1: SHALL be the synchronous level from the core, high while the core is in debug mode.
REQ-008 core_debug_req_o, output, 1: SHALL be the registered halt request to the core.
REQ-009 stoptimer_o, output, 1: SHALL be the registered timer-freeze output to the system timers.
REQ-010 timeout_o, output, 1: SHALL be a registered one-cycle pulse flagging an unacknowledged halt request.
REQ-011 halt_cnt_o, output, 8: SHALL be a registered, saturating count of halt entries.

Function
REQ-012 debug_req_i SHALL pass through SYNC_STAGES flops before use; no other logic SHALL sample it.
REQ-013 The FSM SHALL have states IDLE, REQ, HALTED and RELEASE.
REQ-014 Outputs SHALL be: IDLE (req=0, stop=0); REQ (req=1, stop=0); HALTED (req=0, stop=1); RELEASE (req=0, stop=1).
REQ-015 IDLE->HALTED SHALL occur when core_halted_i=1; this covers core-initiated debug entry and takes priority over the synced request.
REQ-016 IDLE->REQ SHALL occur when the synced request is 1 and core_halted_i=0.
REQ-017 REQ->HALTED SHALL occur when core_halted_i=1; this takes priority over abort and timeout.
REQ-018 REQ->IDLE SHALL occur when the synced request falls to 0 (abort); the timeout counter SHALL clear and timeout_o SHALL not pulse.
REQ-019 The REQ timeout counter SHALL clear on REQ entry and increment every REQ cycle.
REQ-020 When the counter reaches TIMEOUT_CYCLES-1 in REQ, the FSM SHALL return to IDLE and timeout_o SHALL pulse for exactly one cycle.
REQ-021 After a timeout, the FSM SHALL re-enter REQ only after the synced request is seen low for at least one cycle.
REQ-022 HALTED->RELEASE SHALL occur when core_halted_i=0; with RELEASE_CYCLES=0 the FSM SHALL go HALTED->IDLE directly.
REQ-023 RELEASE SHALL last exactly RELEASE_CYCLES cycles and then go to IDLE.
REQ-024 If core_halted_i=1 during RELEASE, the FSM SHALL go back to HALTED; this SHALL not count as a new halt entry.
REQ-025 halt_cnt_o SHALL increment by 1 on every entry to HALTED from IDLE or REQ, and SHALL saturate at 255.
REQ-026 With SYNC_STAGES=2, core_debug_req_o SHALL be high after the 3rd rising edge counted from the first edge that samples debug_req_i high (sync 2 + FSM 1).
REQ-027 stoptimer_o SHALL rise one cycle after core_halted_i is first sampled high in REQ or IDLE.

Reset
REQ-028 On reset_n low, all outputs SHALL go low, halt_cnt_o SHALL be 0, the synchronizer flops and counters SHALL clear, and the FSM SHALL enter IDLE, all asynchronously.
REQ-029 Reset asserted mid-halt SHALL drop stoptimer_o immediately; the block SHALL resume from IDLE on the first edge after reset_n deasserts.

Structure
REQ-030 Package cvmcu_dbg_pkg SHALL hold the FSM state enum and the default values of SYNC_STAGES, TIMEOUT_CYCLES and RELEASE_CYCLES.
REQ-031 The synchronizer SHALL be a separate sub-module, cvmcu_dbg_sync, parameterized by depth, with reset_n clearing every stage.

Verification
REQ-032 Normal halt: debug_req_i=1 -> core_debug_req_o=1 at edge 3; core_halted_i=1 -> stop=1 next cycle, req=0, halt_cnt_o=1.
REQ-033 Resume: in HALTED, drop core_halted_i -> stoptimer_o stays 1 for exactly 4 cycles, then 0, FSM in IDLE.
REQ-034 Timeout: TIMEOUT_CYCLES=8 and core_halted_i held 0 -> timeout_o is a single pulse after 8 REQ cycles; no re-request until debug_req_i toggles low.
REQ-035 Abort and core entry: (a) drop debug_req_i during REQ -> IDLE with no timeout_o; (b) core_halted_i=1 in IDLE -> HALTED with halt_cnt_o incremented.
REQ-036 Saturation and reset: 260 halt cycles -> halt_cnt_o=255; reset_n=0 while HALTED -> stoptimer_o=0 with no clk edge needed.
